// File: rtl/memory_based_fifo_pkg.sv
// Shared constants, operation encoding and sizing helper for memory_based_fifo.
// Optional error flags are enabled by defining MEMORY_BASED_FIFO_ERR_EN.
package memory_based_fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_FIFO_DEPTH = 8;

   // Accepted-operation encoding: {write accepted, read accepted}
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_RW   = 2'b11
   } fifo_op_e;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/memory_based_fifo_mem.sv
// FIFO storage: register array with one write port and a registered read port.
// Ports: clk_i, rst_i (async, clears read register only), we_i/waddr_i/wdata_i,
//        re_i/raddr_i, rdata_o (holds value when re_i is low).
module memory_based_fifo_mem
   import memory_based_fifo_pkg::*;
#(
   parameter int unsigned DW    = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned AW    = ptr_width(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // Storage is deliberately not reset; the control logic never reads
   // a word that has not been written since the last reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_based_fifo.sv
// Synchronous FIFO over a register array; one-cycle registered read data.
// Ports: clk, rst (async active-high), wr_en/din, rd_en/dout, full, empty;
//        overflow/underflow pulses exist only with MEMORY_BASED_FIFO_ERR_EN.
module memory_based_fifo
   import memory_based_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
`ifdef MEMORY_BASED_FIFO_ERR_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam int unsigned AW = ptr_width(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_acc, rd_acc;
   fifo_op_e      op;

   assign full   = (cnt_q == CNT_FULL);
   assign empty  = (cnt_q == '0);

   // A request is only honoured when the matching flag allows it, so a
   // simultaneous request on an empty/full FIFO degrades to one operation.
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;
   assign op     = fifo_op_e'({wr_acc, rd_acc});

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      unique case (op)
         OP_WR: begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + CW'(1);
         end
         OP_RD: begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d    = cnt_q - CW'(1);
         end
         OP_RW: begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   memory_based_fifo_mem #(
      .DW    (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (din),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q),
      .rdata_o (dout)
   );

`ifdef MEMORY_BASED_FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   assign ovf_d = wr_en & full;
   assign unf_d = rd_en & empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_memory_based_fifo.sv
// Self-checking bench for memory_based_fifo against a queue-based model.
// Error-flag checks are compiled in when MEMORY_BASED_FIFO_ERR_EN is defined.
module tb_memory_based_fifo;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       full;
   logic       empty;
`ifdef MEMORY_BASED_FIFO_ERR_EN
   logic       overflow;
   logic       underflow;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   logic [7:0] exp_dout = 8'h00;
   bit         exp_ovf = 1'b0;
   bit         exp_unf = 1'b0;

   memory_based_fifo dut (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty)
`ifdef MEMORY_BASED_FIFO_ERR_EN
      ,
      .overflow  (overflow),
      .underflow (underflow)
`endif
   );

   always #5 clk = ~clk;

   // Applies one cycle of stimulus at a falling edge, advances the model
   // at the rising edge, and returns at the next falling edge.
   task automatic drive(input bit w, input bit r, input logic [7:0] d);
      bit wa, ra;
      wr_en = w;
      rd_en = r;
      din   = d;
      wa = w && (q.size() < DEPTH);
      ra = r && (q.size() > 0);
      @(posedge clk);
      if (ra) exp_dout = q.pop_front();
      if (wa) q.push_back(d);
      exp_ovf = w && !wa;
      exp_unf = r && !ra;
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      q.delete();
      exp_dout = 8'h00;
      repeat (2) @(negedge clk);
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
         errors++;
         $display("FAIL reset_hold empty=%b full=%b dout=%h want 1 0 00",
                  empty, full, dout);
      end
      rst = 1'b0;
      drive(0, 0, 8'h00);
      drive(0, 0, 8'h00);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL idle_empty got %b want 1", empty);
      end
      checks++;
      if (full !== 1'b0) begin
         errors++;
         $display("FAIL idle_full got %b want 0", full);
      end
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL idle_dout got %h want 00", dout);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, 8'((i + 1) * 17));
         checks++;
         if (full !== (i == DEPTH - 1) || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_flags idx=%0d full=%b empty=%b want %b 0",
                     i, full, empty, (i == DEPTH - 1));
         end
      end
      drive(1, 0, 8'hFF);
      checks++;
      if (full !== 1'b1) begin
         errors++;
         $display("FAIL drop_full got %b want 1", full);
      end
`ifdef MEMORY_BASED_FIFO_ERR_EN
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_pulse got %b want 1", overflow);
      end
      drive(0, 0, 8'h00);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clear got %b want 0", overflow);
      end
`endif
   endtask

   task automatic test_drain();
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 1, 8'h00);
         checks++;
         if (dout !== 8'((i + 1) * 17)) begin
            errors++;
            $display("FAIL drain_data idx=%0d got %h want %h",
                     i, dout, 8'((i + 1) * 17));
         end
         checks++;
         if (empty !== (i == DEPTH - 1)) begin
            errors++;
            $display("FAIL drain_empty idx=%0d got %b", i, empty);
         end
      end
      drive(0, 1, 8'h00);
      checks++;
      if (dout !== 8'h88) begin
         errors++;
         $display("FAIL read_empty_hold got %h want 88", dout);
      end
`ifdef MEMORY_BASED_FIFO_ERR_EN
      checks++;
      if (underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow_pulse got %b want 1", underflow);
      end
`endif
   endtask

   task automatic test_empty_rw();
      drive(1, 1, 8'h3C);
      checks++;
      if (dout !== 8'h88 || empty !== 1'b0) begin
         errors++;
         $display("FAIL empty_rw dout=%h empty=%b want 88 0", dout, empty);
      end
      drive(0, 1, 8'h00);
      checks++;
      if (dout !== 8'h3C || empty !== 1'b1) begin
         errors++;
         $display("FAIL empty_rw_read dout=%h empty=%b want 3c 1",
                  dout, empty);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] base;
      base = 8'($urandom);
      for (int i = 0; i < 3; i++) drive(1, 0, 8'($urandom));
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, base + 8'(i));
         checks++;
         if (dout !== exp_dout || empty !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL b2b idx=%0d dout=%h empty=%b full=%b want %h 0 0",
                     i, dout, empty, full, exp_dout);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 8'h00);
         checks++;
         if (dout !== base + 8'(7 + i)) begin
            errors++;
            $display("FAIL b2b_tail idx=%0d got %h want %h",
                     i, dout, base + 8'(7 + i));
         end
      end
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL b2b_empty got %b want 1", empty);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) drive(1, 0, 8'($urandom));
      drive(0, 1, 8'h00);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
         errors++;
         $display("FAIL async_reset empty=%b full=%b dout=%h want 1 0 00",
                  empty, full, dout);
      end
      q.delete();
      exp_dout = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 8'hA5);
      drive(0, 1, 8'h00);
      checks++;
      if (dout !== 8'hA5 || empty !== 1'b1) begin
         errors++;
         $display("FAIL post_reset dout=%h empty=%b want a5 1", dout, empty);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
               8'($urandom));
         checks++;
         if (dout !== exp_dout || full !== (q.size() == DEPTH) ||
             empty !== (q.size() == 0)) begin
            errors++;
            $display("FAIL random idx=%0d dout=%h full=%b empty=%b want %h %b %b",
                     i, dout, full, empty, exp_dout,
                     (q.size() == DEPTH), (q.size() == 0));
         end
`ifdef MEMORY_BASED_FIFO_ERR_EN
         checks++;
         if (overflow !== exp_ovf || underflow !== exp_unf) begin
            errors++;
            $display("FAIL random_err idx=%0d ovf=%b unf=%b want %b %b",
                     i, overflow, underflow, exp_ovf, exp_unf);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_empty_rw();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_based_fifo.md
MEMORY_BASED_FIFO -- requirements
Module: memory_based_fifo

Interface
REQ-001 DATA_WIDTH, default 8, width in bits of din/dout and of each storage word.
REQ-002 FIFO_DEPTH, default 8, number of storage words; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  write request.
REQ-006 rd_en  input  1  read request.
REQ-007 din  input  DATA_WIDTH  write data, sampled on the rising clk edge when a write is accepted.
REQ-008 dout  output  DATA_WIDTH  registered read data.
REQ-009 full  output  1  high when occupancy equals FIFO_DEPTH.
REQ-010 empty  output  1  high when occupancy equals 0.

Function
REQ-011 Storage SHALL be a FIFO_DEPTH x DATA_WIDTH register array addressed by write and read pointers of log2(FIFO_DEPTH) bits.
REQ-012 Write accepted iff wr_en=1 and full=0 at the edge: mem[wr_ptr] <= din; wr_ptr increments modulo FIFO_DEPTH.
REQ-013 Read accepted iff rd_en=1 and empty=0 at the edge: dout <= mem[rd_ptr]; rd_ptr increments modulo FIFO_DEPTH.
REQ-014 Read latency SHALL be one cycle: data is valid on dout after the accepting edge; dout SHALL hold its value on cycles with no accepted read.
REQ-015 Occupancy SHALL be tracked by a count register of log2(FIFO_DEPTH)+1 bits; full and empty SHALL decode combinationally from it.
REQ-016 Write to full FIFO SHALL be dropped; storage, pointers and count unchanged.
REQ-017 Read from empty FIFO SHALL be ignored; dout, pointers and count unchanged.
REQ-018 Simultaneous wr_en and rd_en with 0 < count < FIFO_DEPTH: both accepted; count unchanged.
REQ-019 Simultaneous wr_en and rd_en while empty: only the write is accepted.
REQ-020 Simultaneous wr_en and rd_en while full: only the read is accepted.
REQ-021 Pointer wrap-around from FIFO_DEPTH-1 to 0 SHALL preserve strict first-in-first-out order.

Reset
REQ-022 When rst=1, regardless of clk: wr_ptr=0, rd_ptr=0, count=0, dout=0, empty=1, full=0.
REQ-023 Storage array contents SHALL NOT be reset; stale data is never visible because reads require empty=0.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries; the first write after deassertion goes to address 0.

Configuration
REQ-025 With macro MEMORY_BASED_FIFO_ERR_EN defined, the module SHALL add outputs overflow (1) and underflow (1).
REQ-026 overflow SHALL pulse high for exactly one cycle after a write dropped per REQ-016; underflow likewise for a read ignored per REQ-017; both reset to 0.
REQ-027 Without MEMORY_BASED_FIFO_ERR_EN, those ports and their logic SHALL NOT exist; all other behaviour is identical.

Structure
REQ-028 A package memory_based_fifo_pkg SHALL hold default DATA_WIDTH/FIFO_DEPTH constants and a function computing pointer width (clog2).
REQ-029 One sub-module, memory_based_fifo_mem (write-port register array with synchronous read), is natural; pointer/count/flag control stays in the top.

Verification
REQ-030 Reset, then idle -> empty=1, full=0, dout=8'h00.
REQ-031 Write 8'h11..8'h88 (8 writes) -> full=1 after the 8th edge; a 9th write of 8'hFF is dropped (overflow pulse when ERR_EN).
REQ-032 Read 8 times from the full FIFO -> dout sequence 11,22,...,88, each one cycle after its read; empty=1 after the 8th; a 9th read leaves dout=8'h88.
REQ-033 With 3 entries held, drive wr_en=rd_en=1 for 10 cycles with incrementing din -> count stays 3, order preserved across pointer wrap.
REQ-034 Write 5 entries, assert rst between edges -> empty=1, dout=0 immediately; then write 8'hA5 and read -> dout=8'hA5.
REQ-035 wr_en=rd_en=1 while empty with din=8'h3C -> only write accepted, empty=0, dout unchanged; next read -> dout=8'h3C.
